hex_display_arbiter: RTL and testbench

- Shares the three-digit hex display (HEX_5..HEX_3) among up to N_REQ producers: TDC result, calibration count, status word, etc.
- Producers request with a valid/ready handshake; a round-robin scheduler grants one request at a time.
- The granted 12-bit value is held on the display for HOLD_CYCLES so it is human-readable.
- Output byte_data_send drives the out_hex decoder directly at the top level.

---
 rtl/hex_disp_pkg.sv | 8 +
 rtl/rr_pick.sv | 29 ++
 rtl/hex_display_arbiter.sv | 61 ++++++
 tb/tb_hex_display_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// hex_disp_pkg: shared types and helpers for the hex display arbiter.
package hex_disp_pkg;
  typedef enum logic {IDLE, SHOW} state_e;
  localparam int DISP_W = 12;
  function automatic logic [2:0] mod_inc(input logic [2:0] v, input int n);
    return (int'(v) >= n - 1) ? 3'd0 : v + 3'd1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, search starts one past last_grant.
module rr_pick
  import hex_disp_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [2:0]       last_grant,
  output logic             any_valid,
  output logic [2:0]       winner
);
  logic [7:0] v;
  logic [2:0] c;
  logic       found;
  always_comb begin
    v = 8'(req_valid);
    winner = '0;
    found = 1'b0;
    c = mod_inc(last_grant, N_REQ);
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && v[c]) begin
        winner = c;
        found = 1'b1;
      end
      c = mod_inc(c, N_REQ);
    end
  end
  assign any_valid = |req_valid;
endmodule

// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter: round-robin sharing of the 3-digit hex display,
// each granted value held for HOLD_CYCLES before the next grant.
module hex_display_arbiter
  import hex_disp_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DISP_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DISP_W-1:0]       byte_data_send,
  output logic [2:0]              src_idx,
  output logic                    busy
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [DISP_W-1:0]   data_q, data_d;
  logic [2:0]          idx_q, last_q, winner;
  logic [N_REQ-1:0]    ready_q;
  logic                any_valid, grant;
  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_valid (req_valid),
    .last_grant(last_q),
    .any_valid (any_valid),
    .winner    (winner)
  );
  // Expiry and a fresh grant share one edge, so back-to-back grants never pass through IDLE.
  assign grant  = any_valid && (state_q == IDLE || cnt_q == '0);
  assign data_d = req_data[int'(winner)*DISP_W +: DISP_W];
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 3'(N_REQ - 1);
      ready_q <= '0;
    end else begin
      ready_q <= '0;
      if (grant) begin
        state_q <= SHOW;
        cnt_q   <= CW'(HOLD_CYCLES - 1);
        data_q  <= data_d;
        idx_q   <= winner;
        last_q  <= winner;
        ready_q <= N_REQ'(1) << winner;
      end else if (state_q == SHOW) begin
        if (cnt_q == '0) state_q <= IDLE;
        else cnt_q <= cnt_q - 1'b1;
      end
    end
  end
  assign req_ready      = ready_q;
  assign byte_data_send = data_q;
  assign src_idx        = idx_q;
  assign busy           = (state_q == SHOW);
endmodule

// File: tb/tb_hex_display_arbiter.sv
// tb_hex_display_arbiter: directed vectors with hand-computed expectations.
module tb_hex_display_arbiter;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [47:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [11:0] byte_data_send;
  logic [2:0]  src_idx;
  logic        busy;
  int n_chk = 0;
  int n_fail = 0;

  hex_display_arbiter #(.N_REQ(4), .HOLD_CYCLES(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .byte_data_send(byte_data_send), .src_idx(src_idx), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [11:0] d, input logic [2:0] s,
                      input logic b, input logic [3:0] r);
    check({tag, ".data"}, 32'(byte_data_send), 32'(d));
    check({tag, ".src"}, 32'(src_idx), 32'(s));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".ready"}, 32'(req_ready), 32'(r));
  endtask

  task automatic set_req(input int i, input logic v, input logic [11:0] d);
    req_valid[i] = v;
    req_data[i*12 +: 12] = d;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    #3 RST_N = 1'b0;
    @(negedge CLK);
    outs("reset", 12'h000, 3'd0, 1'b0, 4'b0000);
    RST_N = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      outs("idle", 12'h000, 3'd0, 1'b0, 4'b0000);
    end

    set_req(2, 1'b1, 12'hA5C);
    @(negedge CLK);
    outs("single.grant", 12'hA5C, 3'd2, 1'b1, 4'b0100);
    set_req(2, 1'b0, 12'hA5C);
    for (int i = 1; i < 4; i++) begin
      @(negedge CLK);
      outs("single.hold", 12'hA5C, 3'd2, 1'b1, 4'b0000);
    end
    @(negedge CLK);
    outs("single.idle", 12'hA5C, 3'd2, 1'b0, 4'b0000);

    do_reset();
    req_data = {12'h444, 12'h333, 12'h222, 12'h111};
    req_valid = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      outs("all", 12'h111 * 12'((i / 4) % 4 + 1), 3'((i / 4) % 4), 1'b1,
           (i % 4 == 0) ? 4'(1 << ((i / 4) % 4)) : 4'b0000);
    end
    req_valid = '0;
    @(negedge CLK);
    outs("all.idle", 12'h111, 3'd0, 1'b0, 4'b0000);

    set_req(1, 1'b1, 12'h1B1);
    @(negedge CLK);
    outs("sparse.pre", 12'h1B1, 3'd1, 1'b1, 4'b0010);
    set_req(1, 1'b0, 12'h1B1);
    repeat (4) @(negedge CLK);
    check("sparse.pre_idle", 32'(busy), 32'd0);
    set_req(0, 1'b1, 12'h0A0);
    set_req(3, 1'b1, 12'h3B3);
    @(negedge CLK);
    outs("sparse.first", 12'h3B3, 3'd3, 1'b1, 4'b1000);
    set_req(3, 1'b0, 12'h3B3);
    repeat (3) @(negedge CLK);
    @(negedge CLK);
    outs("sparse.second", 12'h0A0, 3'd0, 1'b1, 4'b0001);
    set_req(0, 1'b0, 12'h0A0);
    for (int j = 1; j < 4; j++) begin
      @(negedge CLK);
      check("coinc.busy", 32'(busy), 32'd1);
    end
    set_req(1, 1'b1, 12'h1C1);
    @(negedge CLK);
    outs("coinc.grant", 12'h1C1, 3'd1, 1'b1, 4'b0010);
    set_req(1, 1'b0, 12'h1C1);
    repeat (4) @(negedge CLK);
    check("coinc.idle", 32'(busy), 32'd0);

    set_req(2, 1'b1, 12'h7F0);
    @(negedge CLK);
    outs("arst.show", 12'h7F0, 3'd2, 1'b1, 4'b0100);
    RST_N = 1'b0;
    #1;
    outs("arst.now", 12'h000, 3'd0, 1'b0, 4'b0000);
    set_req(2, 1'b0, 12'h7F0);
    set_req(1, 1'b1, 12'h1D1);
    set_req(3, 1'b1, 12'h3E3);
    @(negedge CLK);
    outs("arst.held", 12'h000, 3'd0, 1'b0, 4'b0000);
    RST_N = 1'b1;
    @(negedge CLK);
    outs("arst.regrant", 12'h1D1, 3'd1, 1'b1, 4'b0010);
    req_valid = '0;
    repeat (5) @(negedge CLK);
    check("final.idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
